// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encoding, receiver
// FSM states and the layout of a receive-FIFO word.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_INV  = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] ch;
  } rx_word_t;

  localparam int RX_WORD_W = $bits(rx_word_t);

endpackage

// File: rtl/uart_fifo.sv
// Simple synchronous FIFO with a combinational head read. A write while full
// and a read while empty are both ignored.
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_wr   = wr_i & ~full_o;
  assign do_rd   = rd_i & ~empty_o;
  assign rdata_o = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// Oversampling UART deframer: synchronizes RxD, counts Baud_tick pulses and
// emits one {fe, pe, char} word with a single-cycle rx_done per character.
module receiver_fsm
  import uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       d8_i,
  input  logic       s2_i,
  input  logic [1:0] par_i,
  input  logic       rxd_i,
  output rx_word_t   rx_word_o,
  output logic       rx_done_o
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MID = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVS - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    data_q, data_d;
  logic          d8_q, d8_d, s2_q, s2_d, pe_q, pe_d, fe_q, fe_d, stp_q, stp_d;
  logic [1:0]    par_q, par_d;
  logic          parity_on, last_bit, at_end;

  assign rx_s      = sync_q[1];
  assign parity_on = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign last_bit  = d8_q ? (n_q == 3'd7) : (n_q == 3'd6);
  assign at_end    = (cnt_q == CNT_END);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    data_d    = data_q;
    d8_d      = d8_q;
    s2_d      = s2_q;
    par_d     = par_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    stp_d     = stp_q;
    rx_done_o = 1'b0;
    // fe folds in the current stop sample so the write sees the final flag
    rx_word_o = {fe_q | ~rx_s, pe_q, data_q};
    case (state_q)
      RX_IDLE: if (!rx_s) begin
        state_d = RX_START;
        cnt_d   = '0;
      end
      RX_START: if (tick_i) begin
        if (cnt_q == CNT_MID) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            d8_d    = d8_i;
            s2_d    = s2_i;
            par_d   = par_i;
            cnt_d   = '0;
            n_d     = '0;
            data_d  = '0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            stp_d   = 1'b0;
          end else begin
            state_d = RX_IDLE;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_DATA: if (tick_i) begin
        if (at_end) begin
          data_d[n_q] = rx_s;
          cnt_d       = '0;
          n_d         = n_q + 1'b1;
          if (last_bit) state_d = parity_on ? RX_PARITY : RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_PARITY: if (tick_i) begin
        if (at_end) begin
          cnt_d   = '0;
          pe_d    = rx_s != ((par_q == PAR_EVEN) ? ^data_q : ~^data_q);
          state_d = RX_STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
      RX_STOP: if (tick_i) begin
        if (at_end) begin
          cnt_d = '0;
          fe_d  = fe_q | ~rx_s;
          if (stp_q == s2_q) begin
            rx_done_o = 1'b1;
            state_d   = RX_IDLE;
          end else stp_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      data_q  <= '0;
      d8_q    <= 1'b1;
      s2_q    <= 1'b0;
      par_q   <= PAR_NONE;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      stp_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      data_q  <= data_d;
      d8_q    <= d8_d;
      s2_q    <= s2_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      stp_q   <= stp_d;
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver top: deframer feeding a receive FIFO, CPU read edge detect,
// sticky overrun flag and empty-gated head outputs.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK50MHZ,
  input  logic       rst,
  input  logic       Baud_tick,
  input  logic       D_num,
  input  logic       S_num,
  input  logic [1:0] Par,
  input  logic       RxD,
  input  logic       n_RD,
  input  logic       C_nD,
  output logic [7:0] DATA,
  output logic       Rx_RDY,
  output logic       PE,
  output logic       FE,
  output logic       OE
);

  rx_word_t rx_word, head;
  logic     rx_done, empty, full;
  logic     rd_act_q, rd_act_d, oe_q, oe_d;
  logic     rd_edge, pop, stat_rd, ovf;

  receiver_fsm #(.OVS(OVS)) u_rx (
    .clk_i     (CLK50MHZ),
    .rst_i     (rst),
    .tick_i    (Baud_tick),
    .d8_i      (D_num),
    .s2_i      (S_num),
    .par_i     (Par),
    .rxd_i     (RxD),
    .rx_word_o (rx_word),
    .rx_done_o (rx_done)
  );

  uart_fifo #(.WIDTH(RX_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK50MHZ),
    .rst_i   (rst),
    .wr_i    (rx_done),
    .wdata_i (rx_word),
    .rd_i    (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full)
  );

  assign rd_act_d = ~n_RD;
  assign rd_edge  = rd_act_d & ~rd_act_q;
  assign pop      = rd_edge & ~C_nD;
  assign stat_rd  = rd_edge & C_nD;
  // fullness is judged before any same-cycle pop, so a pop cannot rescue it
  assign ovf      = rx_done & full;
  assign oe_d     = ovf | (oe_q & ~stat_rd);

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      rd_act_q <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      rd_act_q <= rd_act_d;
      oe_q     <= oe_d;
    end
  end

  assign Rx_RDY = ~empty;
  assign DATA   = empty ? 8'h00 : head.ch;
  assign PE     = ~empty & head.pe;
  assign FE     = ~empty & head.fe;
  assign OE     = oe_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: frame table plus overrun, false-start
// and mid-frame reset sequences, with a queue of expected FIFO words.
module tb_uart_rx_top;

  localparam int OVS = 16;

  logic       CLK50MHZ = 1'b0;
  logic       rst = 1'b1, Baud_tick = 1'b0, D_num = 1'b1, S_num = 1'b0;
  logic [1:0] Par = 2'b00;
  logic       RxD = 1'b1, n_RD = 1'b1, C_nD = 1'b0;
  logic [7:0] DATA;
  logic       Rx_RDY, PE, FE, OE;

  uart_rx_top #(.OVS(OVS), .FIFO_DEPTH(16)) dut (
    .CLK50MHZ (CLK50MHZ),
    .rst      (rst),
    .Baud_tick(Baud_tick),
    .D_num    (D_num),
    .S_num    (S_num),
    .Par      (Par),
    .RxD      (RxD),
    .n_RD     (n_RD),
    .C_nD     (C_nD),
    .DATA     (DATA),
    .Rx_RDY   (Rx_RDY),
    .PE       (PE),
    .FE       (FE),
    .OE       (OE)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  // one-cycle tick every other clock
  initial forever begin
    @(negedge CLK50MHZ);
    Baud_tick = ~Baud_tick;
  end

  typedef struct {
    string      nm;
    logic       d8;
    logic       s2;
    logic [1:0] par;
    logic [7:0] ch;
    logic       pflip;
    logic [1:0] stopv;
    logic [7:0] edata;
    logic       epe;
    logic       efe;
  } vec_t;

  int         n_tests = 0, n_fail = 0;
  logic [9:0] sb_q[$];
  vec_t       vecs[11];

  function automatic vec_t mkv(input string nm, input logic d8, input logic s2,
                               input logic [1:0] par, input logic [7:0] ch,
                               input logic pf, input logic [1:0] sv,
                               input logic [7:0] ed, input logic epe, input logic efe);
    vec_t v;
    v.nm = nm; v.d8 = d8; v.s2 = s2; v.par = par; v.ch = ch; v.pflip = pf;
    v.stopv = sv; v.edata = ed; v.epe = epe; v.efe = efe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge CLK50MHZ); while (!Baud_tick);
  endtask

  task automatic drive_bit(input logic v, input int nt);
    @(negedge CLK50MHZ);
    RxD = v;
    repeat (nt) wait_tick();
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] d;
    int         nb, ns;
    logic       p;
    @(negedge CLK50MHZ);
    D_num = v.d8; S_num = v.s2; Par = v.par;
    nb = v.d8 ? 8 : 7;
    ns = v.s2 ? 2 : 1;
    d  = v.d8 ? v.ch : {1'b0, v.ch[6:0]};
    drive_bit(1'b0, OVS);
    for (int i = 0; i < nb; i++) drive_bit(d[i], OVS);
    if (v.par == 2'b01 || v.par == 2'b10) begin
      p = (v.par == 2'b10) ? ^d : ~^d;
      drive_bit(p ^ v.pflip, OVS);
    end
    for (int i = 0; i < ns; i++) begin
      // a low final stop bit is cut short so the line is high again
      // before the receiver re-checks it as a possible start bit
      if (!v.stopv[i] && i == ns - 1) drive_bit(1'b0, OVS / 2 + 4);
      else drive_bit(v.stopv[i], OVS);
    end
    drive_bit(1'b1, OVS);
  endtask

  task automatic cpu_read(input logic cnd, input int hold);
    @(negedge CLK50MHZ);
    C_nD = cnd;
    n_RD = 1'b0;
    repeat (hold) @(negedge CLK50MHZ);
    n_RD = 1'b1;
    C_nD = 1'b0;
  endtask

  task automatic check_head(input string nm);
    logic [9:0] e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e = sb_q.pop_front();
      @(negedge CLK50MHZ);
      chk(nm, {Rx_RDY, FE, PE, DATA}, {1'b1, e});
      cpu_read(1'b0, 1);
    end
  endtask

  function automatic vec_t v8n1(input string nm, input logic [7:0] ch);
    return mkv(nm, 1'b1, 1'b0, 2'b00, ch, 1'b0, 2'b11, ch, 1'b0, 1'b0);
  endfunction

  initial begin
    vecs[0]  = mkv("8N1_A5",      1'b1, 1'b0, 2'b00, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0);
    vecs[1]  = mkv("7E2_35_bad",  1'b0, 1'b1, 2'b10, 8'h35, 1'b1, 2'b11, 8'h35, 1'b1, 1'b0);
    vecs[2]  = mkv("7E2_35_ok",   1'b0, 1'b1, 2'b10, 8'h35, 1'b0, 2'b11, 8'h35, 1'b0, 1'b0);
    vecs[3]  = mkv("7O1_35_p1",   1'b0, 1'b0, 2'b01, 8'h35, 1'b0, 2'b11, 8'h35, 1'b0, 1'b0);
    vecs[4]  = mkv("8N1_3C_fe",   1'b1, 1'b0, 2'b00, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1);
    vecs[5]  = mkv("8N2_81_fe2",  1'b1, 1'b1, 2'b00, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1);
    vecs[6]  = mkv("8E1_FF",      1'b1, 1'b0, 2'b10, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0);
    vecs[7]  = mkv("8O1_01_bad",  1'b1, 1'b0, 2'b01, 8'h01, 1'b1, 2'b11, 8'h01, 1'b1, 1'b0);
    vecs[8]  = mkv("8_inv_5A",    1'b1, 1'b0, 2'b11, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0);
    vecs[9]  = mkv("7N1_FF",      1'b0, 1'b0, 2'b00, 8'hFF, 1'b0, 2'b11, 8'h7F, 1'b0, 1'b0);
    vecs[10] = mkv("7E1_pe_fe",   1'b0, 1'b0, 2'b10, 8'h35, 1'b1, 2'b10, 8'h35, 1'b1, 1'b1);

    repeat (3) @(negedge CLK50MHZ);
    rst = 1'b0;
    @(negedge CLK50MHZ);
    chk("reset_outputs", {DATA, Rx_RDY, PE, FE, OE}, 32'h0);

    foreach (vecs[i]) begin
      send_frame(vecs[i]);
      sb_q.push_back({vecs[i].efe, vecs[i].epe, vecs[i].edata});
      check_head(vecs[i].nm);
      chk({vecs[i].nm, "_after_pop"}, {Rx_RDY, DATA}, 32'h0);
    end

    // short low pulse: must be rejected as a false start
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2 * OVS);
    chk("false_start_no_write", Rx_RDY, 32'h0);
    send_frame(v8n1("after_false_start", 8'hC3));
    sb_q.push_back({2'b00, 8'hC3});
    check_head("after_false_start");

    // 17 frames into a 16-deep FIFO: last one overruns
    for (int k = 0; k < 17; k++) begin
      send_frame(v8n1("fill", 8'(k)));
      if (k < 16) sb_q.push_back({2'b00, 8'(k)});
    end
    @(negedge CLK50MHZ);
    chk("overrun_oe_set", {OE, Rx_RDY}, 32'h3);
    cpu_read(1'b1, 1);
    chk("status_read_clears_oe", OE, 32'h0);
    chk("status_read_no_pop", {Rx_RDY, DATA}, {1'b1, 8'h00});
    void'(sb_q.pop_front());
    cpu_read(1'b0, 10);
    @(negedge CLK50MHZ);
    chk("held_read_pops_one", {Rx_RDY, DATA}, {1'b1, 8'h01});
    while (sb_q.size() > 0) check_head("drain");
    chk("drained_empty", {Rx_RDY, DATA}, 32'h0);

    // reset during data bit 3 of 0x5A with an entry already queued
    send_frame(v8n1("pre_reset", 8'h11));
    @(negedge CLK50MHZ);
    D_num = 1'b1; S_num = 1'b0; Par = 2'b00;
    drive_bit(1'b0, OVS);
    drive_bit(1'b0, OVS);
    drive_bit(1'b1, OVS);
    drive_bit(1'b0, OVS);
    drive_bit(1'b1, 5);
    @(negedge CLK50MHZ);
    rst = 1'b1;
    @(negedge CLK50MHZ);
    rst = 1'b0;
    chk("mid_frame_reset", {DATA, Rx_RDY, PE, FE, OE}, 32'h0);
    sb_q.delete();
    drive_bit(1'b1, 3 * OVS);
    chk("reset_no_partial_write", Rx_RDY, 32'h0);
    send_frame(v8n1("post_reset_5A", 8'h5A));
    sb_q.push_back({2'b00, 8'h5A});
    check_head("post_reset_5A");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
UART receiver top level, the counterpart of the transmit path. It oversamples the serial line RxD and deframes characters: 7 or 8 data bits, optional odd/even parity, 1 or 2 stop bits. Each received character goes into a receive FIFO together with its error flags. The CPU pops characters with n_RD/C_nD and reads receiver status.

Parameters:
OVS, 16, Baud_tick pulses per bit period (oversampling factor); must be even and at least 8
FIFO_DEPTH, 16, receive FIFO entries (uart_fifo instance, 10-bit words)

Ports:
CLK50MHZ  input  1  system clock
rst  input  1  reset; synchronous, active-high
Baud_tick  input  1  one-cycle pulse at OVS x baud rate, from the baud rate generator
D_num  input  1  0 = 7 data bits, 1 = 8 data bits
S_num  input  1  0 = 1 stop bit, 1 = 2 stop bits
Par  input  2  00 none, 01 odd, 10 even, 11 invalid (treated as none)
RxD  input  1  serial receive line, asynchronous, idle high
n_RD  input  1  active-low CPU read strobe
C_nD  input  1  0 = data access, 1 = status access
DATA  output  8  FIFO head character; 0 when FIFO empty
Rx_RDY  output  1  FIFO non-empty
PE  output  1  parity error flag of head entry
FE  output  1  framing error flag of head entry
OE  output  1  sticky overrun flag

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; counters clear.
  - Synchronizer flops go to 1.
  - FIFO empties; OE clears.
  - Outputs: DATA=0, Rx_RDY=0, PE=0, FE=0, OE=0.
  - A reset mid-frame discards the partial character.
- RxD passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- The tick counter advances only on Baud_tick.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: at cnt==OVS/2-1, check rx_s.
    - rx_s==0: latch D_num, S_num and Par; cnt=0, bit index n=0; go to DATA.
    - rx_s==1: false start; return to IDLE with no FIFO write.
    - Configuration changes mid-frame are ignored.
  - DATA: at cnt==OVS-1, sample rx_s LSB-first and reset cnt.
    - After 7 or 8 bits: go to PARITY if Par is 01 or 10, else STOP.
    - 7-bit mode: char[7]=0, char[6:0]=received bits.
  - PARITY: sample at cnt==OVS-1.
    - Even: expected bit = XOR of data bits. Odd: expected bit = its inverse.
    - pe = (sample != expected). Go to STOP.
    - With parity none, pe=0.
  - STOP: sample each stop bit at cnt==OVS-1; fe=1 if any stop sample is 0.
    - On the last stop sample, attempt the FIFO write of {fe, pe, char}, then go to IDLE in the same cycle.
    - Next start detection is therefore possible from the middle of the stop bit onward.
- FIFO write:
  - Write only if FIFO is not full in that cycle.
  - If full: the word is dropped and OE is set. A simultaneous pop does not rescue the word.
  - Rx_RDY rises the cycle after the write edge.
- CPU read:
  - rd_act = ~n_RD.
  - Action happens once, on the first cycle rd_act is seen high after being low (registered edge detect). Holding n_RD low does not cause further actions.
  - With C_nD=0: pop FIFO. DATA/PE/FE show the new head the next cycle.
  - With C_nD=1: status read; clears OE the next cycle. If a new overrun occurs in the same cycle, set wins.
  - Pop on an empty FIFO is ignored.
- Output gating: DATA, PE and FE are forced to 0 when the FIFO is empty.

Decomposition:
- Shared package uart_pkg:
  - Par encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_INV).
  - Rx FSM state encoding.
  - FIFO word layout (bit 9 fe, bit 8 pe, bits 7:0 char).
- One sub-module, receiver_fsm: synchronizer, tick/bit counters, deframing, producing rx_word[9:0] and a one-cycle rx_done.
- The top instantiates receiver_fsm plus the existing uart_fifo, and holds the read edge detect and OE logic.

Test Plan:
1. 8N1, OVS=16, send 0xA5 -> after last stop sample Rx_RDY=1, DATA=0xA5, PE=0, FE=0; data read -> Rx_RDY=0 and DATA=0 next cycle.
2. 7E2, send 0x35 with parity bit 1 (correct is 0) -> DATA=0x35, PE=1, FE=0; repeat with parity 0 -> PE=0; 7O1 with 0x35 and parity 1 -> PE=0.
3. 8N1, send 0x3C with stop bit 0, line back high afterwards -> DATA=0x3C, FE=1; a 2-stop frame with only the second stop bit 0 -> FE=1.
4. RxD low for 4 Baud_ticks then high -> no FIFO write, Rx_RDY stays 0, FSM back in IDLE.
5. Send 17 frames 0x00..0x10 without reads -> 16 entries 0x00..0x0F in order, 0x10 dropped, OE=1; status read clears OE; n_RD held low for 10 cycles pops exactly one entry.
6. Assert rst for 1 cycle during data bit 3 -> all outputs 0, FIFO empty; a following clean 0x5A frame is received correctly.
